// File: rtl/pipe_stage_reg.sv
// Reusable pipeline-stage register: valid/ready handshake with a one-entry
// skid buffer, priority flush, occupancy report and saturating stall counter.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      CNT_W     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             out_valid_q;
    logic             in_ready_q;
    logic [1:0]       occ_q;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             accept;
    logic             consume;

    // Handshake qualifiers use only registered flags, so in_ready never
    // depends combinationally on in_valid or out_ready.
    assign accept  = in_valid & in_ready_q;
    assign consume = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = FULL;
                        main_d  = in_data;
                    end
                end
                FULL: begin
                    if (consume && accept) begin
                        main_d = in_data;
                    end else if (consume) begin
                        state_d = EMPTY;
                        main_d  = RESET_VAL;
                    end else if (accept) begin
                        state_d = SKID;
                        skid_d  = in_data;
                    end
                end
                SKID: begin
                    if (consume) begin
                        state_d = FULL;
                        main_d  = skid_q;
                        skid_d  = RESET_VAL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = RESET_VAL;
                    skid_d  = RESET_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= EMPTY;
            main_q      <= RESET_VAL;
            skid_q      <= RESET_VAL;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= (state_d != EMPTY);
            in_ready_q  <= (state_d != SKID);
            occ_q       <= (state_d == SKID) ? 2'd2 :
                           (state_d == FULL) ? 2'd1 : 2'd0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (clr_stats) begin
            stall_d = '0;
        end else if (out_valid_q && !out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three widths driven in lockstep and checked
// every cycle against a queue model, plus directed scenario checks.
module tb_pipe_stage_reg;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        clr_stats = 1'b0;
    logic [95:0] din = '0;

    logic        m_in_ready, m_out_valid;
    logic [31:0] m_out_data;
    logic [1:0]  m_occ;
    logic [3:0]  m_stall;

    logic        a_in_ready, a_out_valid;
    logic [0:0]  a_out_data;
    logic [1:0]  a_occ;
    logic [15:0] a_stall;

    logic        b_in_ready, b_out_valid;
    logic [95:0] b_out_data;
    logic [1:0]  b_occ;
    logic [15:0] b_stall;

    int n_chk = 0;
    int n_fail = 0;

    logic [95:0] q[$];
    int unsigned s4 = 0;
    int unsigned s16 = 0;

    always #5 CLK = ~CLK;

    pipe_stage_reg #(.WIDTH(32), .CNT_W(4)) u_main (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_data(din[31:0]), .in_ready(m_in_ready),
        .out_valid(m_out_valid), .out_data(m_out_data), .out_ready(out_ready),
        .occupancy(m_occ), .clr_stats(clr_stats), .stall_cnt(m_stall)
    );

    pipe_stage_reg #(.WIDTH(1)) u_w1 (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_data(din[0:0]), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(out_ready),
        .occupancy(a_occ), .clr_stats(clr_stats), .stall_cnt(a_stall)
    );

    pipe_stage_reg #(.WIDTH(96)) u_w96 (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_data(din), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(out_ready),
        .occupancy(b_occ), .clr_stats(clr_stats), .stall_cnt(b_stall)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [95:0] h;
        logic        v;
        logic        r;
        logic [1:0]  d;
        h = (q.size() > 0) ? q[0] : 96'd0;
        v = (q.size() > 0);
        r = (q.size() < 2);
        d = 2'(q.size());
        chk("m_valid", 128'(m_out_valid), 128'(v));
        chk("m_ready", 128'(m_in_ready), 128'(r));
        chk("m_occ",   128'(m_occ),       128'(d));
        chk("m_data",  128'(m_out_data),  128'(h[31:0]));
        chk("m_stall", 128'(m_stall),     128'(s4));
        chk("a_valid", 128'(a_out_valid), 128'(v));
        chk("a_ready", 128'(a_in_ready),  128'(r));
        chk("a_occ",   128'(a_occ),       128'(d));
        chk("a_data",  128'(a_out_data),  128'(h[0]));
        chk("a_stall", 128'(a_stall),     128'(s16));
        chk("b_valid", 128'(b_out_valid), 128'(v));
        chk("b_ready", 128'(b_in_ready),  128'(r));
        chk("b_occ",   128'(b_occ),       128'(d));
        chk("b_data",  128'(b_out_data),  128'(h));
        chk("b_stall", 128'(b_stall),     128'(s16));
    endtask

    // One clock: update the queue model from the pre-edge view, then check.
    task automatic tick();
        bit acc;
        bit con;
        bit stl;
        @(posedge CLK);
        acc = in_valid && (q.size() < 2);
        con = (q.size() > 0) && out_ready;
        stl = (q.size() > 0) && !out_ready;
        if (RST) begin
            q.delete();
            s4 = 0;
            s16 = 0;
        end else begin
            if (clr_stats) begin
                s4 = 0;
                s16 = 0;
            end else if (stl) begin
                if (s4 < 15) s4++;
                if (s16 < 65535) s16++;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (con) void'(q.pop_front());
                if (acc) q.push_back(din);
            end
        end
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input logic [95:0] d);
        in_valid = v;
        din = d;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_valid", 128'(m_out_valid), 128'(0));
        chk("rst_ready", 128'(m_in_ready), 128'(1));
        chk("rst_occ", 128'(m_occ), 128'(0));
        RST = 1'b0;
        tick();

        out_ready = 1'b1;
        drive(1, 96'h11);
        tick();
        chk("stream_11", 128'(m_out_data), 128'(32'h11));
        drive(1, 96'h22);
        tick();
        chk("stream_22", 128'(m_out_data), 128'(32'h22));
        drive(1, 96'h33);
        tick();
        chk("stream_33", 128'(m_out_data), 128'(32'h33));
        chk("stream_occ", 128'(m_occ), 128'(1));
        chk("stream_stall", 128'(m_stall), 128'(0));
        drive(0, 96'h0);
        tick();

        out_ready = 1'b0;
        drive(1, 96'hA);
        tick();
        drive(1, 96'hB);
        tick();
        chk("skid_occ", 128'(m_occ), 128'(2));
        chk("skid_ready", 128'(m_in_ready), 128'(0));
        drive(1, 96'hC);
        tick();
        chk("skid_hold", 128'(m_out_data), 128'(32'hA));
        chk("skid_occ2", 128'(m_occ), 128'(2));
        out_ready = 1'b1;
        tick();
        chk("drain_B", 128'(m_out_data), 128'(32'hB));
        tick();
        chk("drain_C", 128'(m_out_data), 128'(32'hC));
        drive(0, 96'h0);
        tick();
        chk("drain_empty", 128'(m_occ), 128'(0));

        out_ready = 1'b0;
        drive(1, 96'hA);
        tick();
        drive(1, 96'hB);
        tick();
        flush = 1'b1;
        drive(1, 96'hD);
        tick();
        chk("flush_valid", 128'(m_out_valid), 128'(0));
        chk("flush_data", 128'(m_out_data), 128'(0));
        flush = 1'b0;
        drive(0, 96'h0);
        tick();
        chk("flush_noD", 128'(m_out_valid), 128'(0));

        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        drive(1, 96'h5A);
        tick();
        drive(0, 96'h0);
        for (int i = 0; i < 20; i++) tick();
        chk("stall_sat", 128'(m_stall), 128'(15));
        chk("stall_w16", 128'(a_stall), 128'(20));
        clr_stats = 1'b1;
        tick();
        chk("stall_clr", 128'(m_stall), 128'(0));
        clr_stats = 1'b0;
        tick();
        chk("stall_again", 128'(m_stall), 128'(1));
        out_ready = 1'b1;
        tick();

        for (int i = 0; i < 1000; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = (i < 500) ? (($urandom % 2) != 0)
                                  : (($urandom % 3) != 0);
            flush     = ($urandom % 40) == 0;
            clr_stats = ($urandom % 50) == 0;
            din       = {$urandom, $urandom, $urandom};
            tick();
        end
        flush = 1'b0;
        clr_stats = 1'b0;

        out_ready = 1'b0;
        drive(1, 96'hA);
        tick();
        drive(1, 96'hB);
        tick();
        chk("pre_rst_occ", 128'(m_occ), 128'(2));
        RST = 1'b1;
        #2;
        q.delete();
        s4 = 0;
        s16 = 0;
        chk("arst_valid", 128'(m_out_valid), 128'(0));
        chk("arst_ready", 128'(m_in_ready), 128'(1));
        chk("arst_occ", 128'(m_occ), 128'(0));
        chk("arst_data", 128'(m_out_data), 128'(0));
        chk("arst_stall", 128'(m_stall), 128'(0));
        check_all();
        tick();
        RST = 1'b0;
        out_ready = 1'b1;
        drive(1, 96'h77);
        tick();
        chk("post_rst", 128'(m_out_data), 128'(32'h77));
        drive(0, 96'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline-stage register with a valid/ready handshake and a one-entry skid buffer.
- Replaces fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block carrying a packed payload of WIDTH bits.
- Adds back-pressure without combinational ready paths, priority flush, occupancy reporting and a saturating stall counter for performance debug.

Parameters:
WIDTH, 32, payload width in bits (packed control plus data fields of the stage)
CNT_W, 16, stall-counter width in bits
RESET_VAL, '0, payload value loaded on reset, flush and drain-to-empty

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous reset, active-high
flush  input  1  synchronous squash of all held entries
in_valid  input  1  upstream offers in_data
in_data  input  WIDTH  upstream payload
in_ready  output  1  stage accepts in_data this cycle
out_valid  output  1  out_data holds a valid entry
out_data  output  WIDTH  payload to downstream
out_ready  input  1  downstream consumes out_data this cycle
occupancy  output  2  number of held entries (0, 1 or 2)
clr_stats  input  1  synchronous clear of stall_cnt
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage: main register (drives out_data) and skid register. States: EMPTY, FULL (main only), SKID (main+skid).
- All outputs come straight from registers; there is no combinational path from in_valid or out_ready to in_ready.
- out_valid = (state != EMPTY).
- in_ready = (state != SKID).
- occupancy: EMPTY=0, FULL=1, SKID=2.
- Handshakes: accept = in_valid & in_ready; consume = out_valid & out_ready.
- Transitions when flush=0:
  - EMPTY: accept -> FULL, main<=in_data. Otherwise stay.
  - FULL: consume & accept -> FULL, main<=in_data.
  - FULL: consume & !accept -> EMPTY, main<=RESET_VAL.
  - FULL: !consume & accept -> SKID, skid<=in_data, main held.
  - FULL: neither -> hold.
  - SKID: consume -> FULL, main<=skid, skid<=RESET_VAL. in_ready=0, so no accept occurs.
  - SKID: !consume -> hold.
- Latency: an entry accepted into EMPTY appears on out_data with out_valid=1 the next cycle (1-cycle latency).
- Order: strict FIFO. The skid entry is never overtaken.
- Flush (highest synchronous priority):
  - Next state EMPTY; main and skid <= RESET_VAL.
  - An input offered in the same cycle is dropped, even if in_ready was 1.
  - A downstream consume in the same cycle still counts for the consumer; the stage still clears.
- Stall counter:
  - Increments by 1 each cycle out_valid & !out_ready; saturates at 2^CNT_W-1.
  - clr_stats loads 0 and has priority over increment.
  - flush does not clear stall_cnt.
- Reset (RST=1, any time, asynchronous):
  - State EMPTY; main = skid = RESET_VAL; stall_cnt = 0.
  - Hence out_valid=0, in_ready=1, occupancy=0.
  - Any mid-handshake entries are lost; the first accept after deassertion behaves as from EMPTY.
- Payload is opaque: no field decode or arithmetic on in_data.

Test Plan:
- Reset/idle: assert RST mid-stream with occupancy=2 -> immediately out_valid=0, in_ready=1, occupancy=0, out_data=0, stall_cnt=0.
- Streaming: in_valid=1 with in_data=0x11,0x22,0x33 on consecutive cycles, out_ready=1 -> out_data 0x11,0x22,0x33 one cycle later, occupancy stays 1, in_ready stays 1, stall_cnt=0.
- Skid fill/drain: load 0xA, hold out_ready=0, offer 0xB -> occupancy=2, in_ready=0, out_data=0xA. Offer 0xC while full -> not accepted. Release out_ready -> outputs 0xA,0xB,0xC in order, no loss or duplication.
- Flush: occupancy=2 (0xA,0xB), pulse flush with in_valid=1, in_data=0xD -> next cycle EMPTY, out_valid=0, out_data=RESET_VAL, 0xD never appears.
- Stall counter: CNT_W=4, hold a valid entry with out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays. clr_stats together with a stall -> stall_cnt=0 next cycle.
- Randomised back-pressure: random in_valid/out_ready over 1000 cycles against a scoreboard queue, WIDTH=1 and WIDTH=96 -> no drop, no reorder, occupancy always equals the model depth.
